// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the instruction fetch stage.
package fetch_unit_pkg;

    localparam logic [31:0] INST_NOP       = 32'h0000_0013;
    localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; flush beats push, and push+pop is legal when full.
module fetch_fifo #(
    parameter int unsigned     Width    = 64,
    parameter int unsigned     Depth    = 2,
    parameter logic [Width-1:0] ResetVal = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [Width-1:0]         wdata,
    output logic [Width-1:0]         rdata,
    output logic [$clog2(Depth):0]   count,
    output logic                     empty
);

    localparam int unsigned AW   = $clog2(Depth);
    localparam int unsigned CntW = AW + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q, count_d;
    logic             full, do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CntW'(Depth));
    assign do_push = push && !flush && (!full || pop);
    assign do_pop  = pop && !flush && !empty;
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CntW'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                mem_q[i] <= ResetVal;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues credit-limited in-order requests and
// buffers returned words for decode; redirects flush buffered and in-flight work.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0]  RESET_PC   = FETCH_RESET_PC,
    parameter int unsigned  FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 2;

    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW-1:0] in_use;
    logic [AW:0]   occupancy;
    logic          empty, pop, req_fire, push;
    fetch_entry_t  head, push_entry;

    assign pop      = inst_valid && inst_ready;
    assign in_use   = outstanding_q + CW'(occupancy) - CW'(pop);
    // Gated by rst_n so the request line reads idle while reset is held.
    assign imem_req_valid = rst_n && !redirect_valid && (in_use < CW'(FIFO_DEPTH));
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Once drop is zero every outstanding request came from the current stream,
    // so the oldest one sits 4*outstanding bytes behind the next PC.
    assign push            = imem_rsp_valid && (drop_q == '0);
    assign push_entry.pc   = pc_q - 32'({outstanding_q, 2'b00});
    assign push_entry.data = imem_rsp_data;

    always_comb begin
        pc_d          = pc_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        if (req_fire) begin
            pc_d          = pc_q + 32'd4;
            outstanding_d = outstanding_q + CW'(1);
        end
        if (imem_rsp_valid) begin
            outstanding_d = outstanding_d - CW'(1);
            if (drop_q != '0) begin
                drop_d = drop_q - CW'(1);
            end
        end
        if (redirect_valid) begin
            pc_d   = word_align(redirect_pc);
            drop_d = outstanding_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    fetch_fifo #(
        .Width    ($bits(fetch_entry_t)),
        .Depth    (FIFO_DEPTH),
        .ResetVal ({RESET_PC, INST_NOP})
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata (push_entry),
        .rdata (head),
        .count (occupancy),
        .empty (empty)
    );

    assign inst_valid = !empty;
    assign inst       = head.data;
    assign inst_pc    = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a latency-configurable in-order memory model.
`timescale 1ns/1ps
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    int checks = 0;
    int errors = 0;

    fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_BEEF;
    endfunction

    // Memory model: accept sampled mid-cycle, response driven 1ns after the edge
    int unsigned lat = 1;
    bit          rand_ready = 1'b0;
    logic [31:0] q_addr[$];
    int unsigned q_due[$];
    int unsigned cyc = 0;

    initial begin
        logic        fire_s;
        logic [31:0] fire_addr;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            fire_s    = imem_req_valid && imem_req_ready;
            fire_addr = imem_req_addr;
            @(posedge clk);
            if (rst_n && fire_s) begin
                q_addr.push_back(fire_addr);
                q_due.push_back(cyc + lat);
            end
            cyc++;
            #1;
            if (!rst_n) begin
                q_addr.delete();
                q_due.delete();
            end
            imem_rsp_valid = 1'b0;
            if (q_addr.size() > 0 && q_due[0] <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(q_addr.pop_front());
                void'(q_due.pop_front());
            end
            imem_req_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Leaves the bench at the start of cycle 0 (reset just released).
    task automatic start(input int unsigned latency, input logic rdy);
        rst_n = 1'b0;
        #1;
        lat            = latency;
        rand_ready     = 1'b0;
        inst_ready     = rdy;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        inst_ready     = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        tick();
        tick();
        #1;
        checks++;
        if (imem_req_valid !== 1'b0) begin
            errors++; $display("FAIL reset_req_valid: got %b want 0", imem_req_valid);
        end
        checks++;
        if (imem_req_addr !== 32'h0) begin
            errors++; $display("FAIL reset_req_addr: got %h want 00000000", imem_req_addr);
        end
        checks++;
        if (inst_valid !== 1'b0) begin
            errors++; $display("FAIL reset_inst_valid: got %b want 0", inst_valid);
        end
        checks++;
        if (inst !== 32'h0000_0013) begin
            errors++; $display("FAIL reset_inst: got %h want 00000013", inst);
        end
        checks++;
        if (inst_pc !== 32'h0) begin
            errors++; $display("FAIL reset_inst_pc: got %h want 00000000", inst_pc);
        end
    endtask

    task automatic test_stream();
        start(1, 1'b1);
        for (int c = 0; c < 10; c++) begin
            if (c > 0) tick();
            #1;
            checks++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'(4 * c)) begin
                errors++;
                $display("FAIL stream_req c=%0d: got v=%b a=%h want v=1 a=%h",
                         c, imem_req_valid, imem_req_addr, 32'(4 * c));
            end
            if (c >= 2) begin
                checks++;
                if (inst_valid !== 1'b1 || inst_pc !== 32'(4 * (c - 2)) ||
                    inst !== mem_word(32'(4 * (c - 2)))) begin
                    errors++;
                    $display("FAIL stream_inst c=%0d: got v=%b pc=%h i=%h want v=1 pc=%h i=%h",
                             c, inst_valid, inst_pc, inst, 32'(4 * (c - 2)),
                             mem_word(32'(4 * (c - 2))));
                end
            end else begin
                checks++;
                if (inst_valid !== 1'b0) begin
                    errors++; $display("FAIL stream_early c=%0d: got v=%b want 0", c, inst_valid);
                end
            end
        end
    endtask

    task automatic test_stall();
        logic        exp_v;
        logic [31:0] exp_a;
        logic [31:0] exp_pc;
        start(1, 1'b0);
        for (int c = 0; c < 10; c++) begin
            if (c > 0) tick();
            inst_ready = (c >= 5);
            #1;
            exp_v = (c < 2) || (c >= 5);
            exp_a = (c < 2) ? 32'(4 * c) : 32'(4 * (c - 3));
            checks++;
            if (imem_req_valid !== exp_v || (exp_v && imem_req_addr !== exp_a)) begin
                errors++;
                $display("FAIL stall_req c=%0d: got v=%b a=%h want v=%b a=%h",
                         c, imem_req_valid, imem_req_addr, exp_v, exp_a);
            end
            checks++;
            if (32'(dut.outstanding_q) + 32'(dut.occupancy) > 32'd2) begin
                errors++;
                $display("FAIL stall_credit c=%0d: got %0d in use want <= 2",
                         c, 32'(dut.outstanding_q) + 32'(dut.occupancy));
            end
            if (c >= 2) begin
                exp_pc = (c < 5) ? 32'h0 : 32'(4 * (c - 5));
                checks++;
                if (inst_valid !== 1'b1 || inst_pc !== exp_pc || inst !== mem_word(exp_pc)) begin
                    errors++;
                    $display("FAIL stall_inst c=%0d: got v=%b pc=%h i=%h want v=1 pc=%h i=%h",
                             c, inst_valid, inst_pc, inst, exp_pc, mem_word(exp_pc));
                end
            end
        end
    endtask

    task automatic test_redirect_flush();
        logic        exp_v [10] = '{1, 1, 0, 0, 1, 1, 0, 0, 1, 1};
        logic [31:0] exp_a [10] = '{32'h0, 32'h4, 32'h0, 32'h0, 32'h100, 32'h104,
                                    32'h0, 32'h0, 32'h108, 32'h10C};
        logic [31:0] exp_pc;
        start(3, 1'b1);
        for (int c = 0; c < 10; c++) begin
            if (c > 0) tick();
            redirect_valid = (c == 2);
            redirect_pc    = 32'h100;
            #1;
            checks++;
            if (imem_req_valid !== exp_v[c] || (exp_v[c] && imem_req_addr !== exp_a[c])) begin
                errors++;
                $display("FAIL flush_req c=%0d: got v=%b a=%h want v=%b a=%h",
                         c, imem_req_valid, imem_req_addr, exp_v[c], exp_a[c]);
            end
            if (c < 8) begin
                checks++;
                if (inst_valid !== 1'b0) begin
                    errors++; $display("FAIL flush_stale c=%0d: got v=%b want 0", c, inst_valid);
                end
            end else begin
                exp_pc = 32'h100 + 32'(4 * (c - 8));
                checks++;
                if (inst_valid !== 1'b1 || inst_pc !== exp_pc || inst !== mem_word(exp_pc)) begin
                    errors++;
                    $display("FAIL flush_inst c=%0d: got v=%b pc=%h i=%h want v=1 pc=%h i=%h",
                             c, inst_valid, inst_pc, inst, exp_pc, mem_word(exp_pc));
                end
            end
            if (c >= 5) begin
                checks++;
                if (dut.drop_q !== '0) begin
                    errors++; $display("FAIL flush_drop c=%0d: got %0d want 0", c, dut.drop_q);
                end
            end
        end
        redirect_valid = 1'b0;
    endtask

    task automatic test_redirect_align();
        logic [31:0] exp_a;
        logic [31:0] exp_pc;
        start(1, 1'b1);
        for (int c = 0; c < 9; c++) begin
            if (c > 0) tick();
            redirect_valid = (c == 3);
            redirect_pc    = 32'h203;
            #1;
            exp_a = (c < 3) ? 32'(4 * c) : 32'h200 + 32'(4 * (c - 4));
            checks++;
            if (imem_req_valid !== (c != 3) || (c != 3 && imem_req_addr !== exp_a)) begin
                errors++;
                $display("FAIL align_req c=%0d: got v=%b a=%h want v=%b a=%h",
                         c, imem_req_valid, imem_req_addr, c != 3, exp_a);
            end
            if (c == 4 || c == 5) begin
                checks++;
                if (inst_valid !== 1'b0) begin
                    errors++; $display("FAIL align_gap c=%0d: got v=%b want 0", c, inst_valid);
                end
            end else if (c >= 2) begin
                exp_pc = (c < 4) ? 32'(4 * (c - 2)) : 32'h200 + 32'(4 * (c - 6));
                checks++;
                if (inst_valid !== 1'b1 || inst_pc !== exp_pc || inst !== mem_word(exp_pc)) begin
                    errors++;
                    $display("FAIL align_inst c=%0d: got v=%b pc=%h i=%h want v=1 pc=%h i=%h",
                             c, inst_valid, inst_pc, inst, exp_pc, mem_word(exp_pc));
                end
            end
        end
        redirect_valid = 1'b0;
    endtask

    task automatic test_random_latency();
        logic [31:0] exp_req = 32'h0;
        logic [31:0] exp_pc  = 32'h0;
        int          pops    = 0;
        start(3, 1'b1);
        rand_ready = 1'b1;
        for (int c = 0; c < 300; c++) begin
            if (c > 0) tick();
            inst_ready = 1'($urandom_range(0, 1));
            #1;
            if (imem_req_valid) begin
                checks++;
                if (imem_req_addr !== exp_req) begin
                    errors++;
                    $display("FAIL rand_req_addr c=%0d: got %h want %h", c, imem_req_addr, exp_req);
                end
                if (imem_req_ready) exp_req = exp_req + 32'd4;
            end
            if (inst_valid && inst_ready) begin
                checks++;
                if (inst_pc !== exp_pc || inst !== mem_word(exp_pc)) begin
                    errors++;
                    $display("FAIL rand_inst c=%0d: got pc=%h i=%h want pc=%h i=%h",
                             c, inst_pc, inst, exp_pc, mem_word(exp_pc));
                end
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
            checks++;
            if (dut.u_fifo.push && dut.u_fifo.full && !dut.u_fifo.pop) begin
                errors++;
                $display("FAIL rand_full_push c=%0d: got push into full fifo want none", c);
            end
        end
        checks++;
        if (pops < 30) begin
            errors++; $display("FAIL rand_progress: got %0d pops want >= 30", pops);
        end
        rand_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        start(1, 1'b0);
        tick(); tick(); tick();
        #1;
        checks++;
        if (inst_valid !== 1'b1) begin
            errors++; $display("FAIL areset_pre: got v=%b want 1", inst_valid);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (inst_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL areset_clear: got iv=%b rv=%b want iv=0 rv=0",
                     inst_valid, imem_req_valid);
        end
        checks++;
        if (inst !== INST_NOP || inst_pc !== 32'h0) begin
            errors++;
            $display("FAIL areset_head: got i=%h pc=%h want i=00000013 pc=00000000", inst, inst_pc);
        end
        tick();
        tick();
        rst_n      = 1'b1;
        inst_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) tick();
            #1;
            checks++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'(4 * c)) begin
                errors++;
                $display("FAIL areset_restart c=%0d: got v=%b a=%h want v=1 a=%h",
                         c, imem_req_valid, imem_req_addr, 32'(4 * c));
            end
            if (c >= 2) begin
                checks++;
                if (inst_valid !== 1'b1 || inst_pc !== 32'(4 * (c - 2))) begin
                    errors++;
                    $display("FAIL areset_inst c=%0d: got v=%b pc=%h want v=1 pc=%h",
                             c, inst_valid, inst_pc, 32'(4 * (c - 2)));
                end
            end
        end
    endtask

    initial begin
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect_flush();
        test_redirect_align();
        test_random_latency();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
